// File: rtl/w6_data2304_rd_sched_pkg.sv
// Shared constants and types for the w6_data2304 read scheduler.
// Port numbers follow the memory CE/A index: 0 is the write port, 1..8 are read ports.
package w6_mem_sched_pkg;

    localparam int NHB = 4;

    typedef logic [3:0] port_idx_t;
    typedef logic [3:0] req_idx_t;

    typedef struct packed {
        logic     vld;
        req_idx_t idx;
    } pick_t;

    localparam port_idx_t SLOT0_PORT [NHB] = '{4'd1, 4'd3, 4'd6, 4'd8};
    localparam port_idx_t SLOT1_PORT [NHB] = '{4'd2, 4'd4, 4'd5, 4'd7};

    // (base + k) mod n for base < n and k < n.
    function automatic req_idx_t rr_idx(input req_idx_t base, input int k, input int n);
        int s;
        s = int'(base) + k;
        if (s >= n) s = s - n;
        return req_idx_t'(s);
    endfunction

endpackage

// File: rtl/w6_data2304_rd_sched_rr_pick.sv
// Rotating-priority scan for one h-bank: the first two eligible requesters from the
// pointer take slot0 and slot1, or only slot1 when slot0 already belongs to the write.
module mem_rr_pick
    import w6_mem_sched_pkg::*;
#(
    parameter int NREQ = 8
) (
    input  req_idx_t        i_ptr,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_slot0_taken,
    output pick_t           o_slot0,
    output pick_t           o_slot1
);

    logic [15:0] w_req16;
    req_idx_t    w_idx;
    pick_t       w_s0;
    pick_t       w_s1;

    assign w_req16 = 16'(i_req);

    always_comb begin
        w_s0  = '0;
        w_s1  = '0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = rr_idx(i_ptr, k, NREQ);
            if (w_req16[w_idx]) begin
                if (!i_slot0_taken && !w_s0.vld) begin
                    w_s0.vld = 1'b1;
                    w_s0.idx = w_idx;
                end else if (!w_s1.vld) begin
                    w_s1.vld = 1'b1;
                    w_s1.idx = w_idx;
                end
            end
        end
    end

    assign o_slot0 = w_s0;
    assign o_slot1 = w_s1;

endmodule

// File: rtl/w6_data2304_rd_sched.sv
// Schedules NREQ readers and one writer onto the 1W/8R banked memory w6_data2304_1w8r,
// keeping every bank port single-use per cycle and returning read data one cycle later.
module w6_data2304_rd_sched
    import w6_mem_sched_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int AW   = 3,
    parameter int DW   = 2304
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     rd_valid,
    input  logic [NREQ*AW-1:0]  rd_addr,
    output logic [NREQ-1:0]     rd_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [NREQ*DW-1:0]  rsp_data,
    input  logic                wr_valid,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [DW-1:0]       wr_mask,
    output logic                wr_ready,
    output logic [8:0]          mem_CE,
    output logic [9*AW-1:0]     mem_A,
    output logic [DW-1:0]       mem_D,
    output logic [DW-1:0]       mem_WEM,
    output logic                mem_WE,
    input  logic [8*DW-1:0]     mem_Q
);

    logic            w_wr_go;
    logic [AW-1:0]   w_addr16 [16];
    logic [15:0]     w_elig16;
    logic [NREQ-1:0] w_req_hb [NHB];
    pick_t           w_pick0 [NHB];
    pick_t           w_pick1 [NHB];
    logic [15:0]     w_gnt16;
    port_idx_t       w_port16 [16];
    req_idx_t        w_scan;
    req_idx_t        w_last_gnt;
    logic            w_any_gnt;
    req_idx_t        w_rr_nxt;
    req_idx_t        r_rr_ptr;
    logic [NREQ-1:0] r_rsp_valid;
    port_idx_t       r_rsp_port [NREQ];

    assign w_wr_go  = wr_valid & ~RST;
    assign wr_ready = w_wr_go;

    // A read aimed at the address being written is held off so it never sees colliding data.
    always_comb begin
        w_elig16 = '0;
        for (int r = 0; r < 16; r++) w_addr16[r] = '0;
        for (int r = 0; r < NREQ; r++) begin
            w_addr16[r] = rd_addr[r*AW +: AW];
            w_elig16[r] = rd_valid[r] & ~(wr_valid & (rd_addr[r*AW +: AW] == wr_addr));
        end
    end

    always_comb begin
        for (int h = 0; h < NHB; h++) begin
            w_req_hb[h] = '0;
            for (int r = 0; r < NREQ; r++)
                w_req_hb[h][r] = w_elig16[r] & (w_addr16[r][1:0] == 2'(h));
        end
    end

    for (genvar h = 0; h < NHB; h++) begin : g_hb
        mem_rr_pick #(.NREQ(NREQ)) u_pick (
            .i_ptr         (r_rr_ptr),
            .i_req         (w_req_hb[h]),
            .i_slot0_taken (wr_valid & (wr_addr[1:0] == 2'(h))),
            .o_slot0       (w_pick0[h]),
            .o_slot1       (w_pick1[h])
        );
    end

    always_comb begin
        w_gnt16 = '0;
        for (int r = 0; r < 16; r++) w_port16[r] = '0;
        for (int h = 0; h < NHB; h++) begin
            if (w_pick0[h].vld) begin
                w_gnt16[w_pick0[h].idx]  = 1'b1;
                w_port16[w_pick0[h].idx] = SLOT0_PORT[h];
            end
            if (w_pick1[h].vld) begin
                w_gnt16[w_pick1[h].idx]  = 1'b1;
                w_port16[w_pick1[h].idx] = SLOT1_PORT[h];
            end
        end
    end

    assign rd_ready = w_gnt16[NREQ-1:0] & {NREQ{~RST}};

    // Pointer moves past the last grant in scan order, so a skipped requester leads next cycle.
    always_comb begin
        w_any_gnt  = 1'b0;
        w_last_gnt = '0;
        w_scan     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = rr_idx(r_rr_ptr, k, NREQ);
            if (w_gnt16[w_scan]) begin
                w_any_gnt  = 1'b1;
                w_last_gnt = w_scan;
            end
        end
        w_rr_nxt = w_any_gnt ? rr_idx(w_last_gnt, 1, NREQ) : r_rr_ptr;
    end

    always_comb begin
        mem_CE         = '0;
        mem_A          = '0;
        mem_CE[0]      = w_wr_go;
        mem_A[0 +: AW] = w_wr_go ? wr_addr : '0;
        if (!RST) begin
            for (int p = 1; p <= 8; p++) begin
                for (int h = 0; h < NHB; h++) begin
                    if (w_pick0[h].vld && SLOT0_PORT[h] == port_idx_t'(p)) begin
                        mem_CE[p]         = 1'b1;
                        mem_A[p*AW +: AW] = w_addr16[w_pick0[h].idx];
                    end
                    if (w_pick1[h].vld && SLOT1_PORT[h] == port_idx_t'(p)) begin
                        mem_CE[p]         = 1'b1;
                        mem_A[p*AW +: AW] = w_addr16[w_pick1[h].idx];
                    end
                end
            end
        end
    end

    assign mem_WE  = w_wr_go;
    assign mem_D   = w_wr_go ? wr_data : '0;
    assign mem_WEM = w_wr_go ? wr_mask : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            for (int r = 0; r < NREQ; r++) r_rsp_port[r] <= '0;
        end else begin
            r_rr_ptr    <= w_rr_nxt;
            r_rsp_valid <= rd_valid & rd_ready;
            for (int r = 0; r < NREQ; r++) r_rsp_port[r] <= w_port16[r];
        end
    end

    assign rsp_valid = r_rsp_valid;

    always_comb begin
        rsp_data = '0;
        for (int r = 0; r < NREQ; r++) begin
            for (int p = 1; p <= 8; p++) begin
                if (r_rsp_port[r] == port_idx_t'(p))
                    rsp_data[r*DW +: DW] = mem_Q[(p-1)*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_w6_data2304_rd_sched.sv
// Scoreboard bench for w6_data2304_rd_sched with a behavioural 1W/8R memory model
// and a slot-counting arbitration reference.
module tb_w6_data2304_rd_sched;

    localparam int NREQ = 8;
    localparam int AW   = 3;
    localparam int DW   = 2304;
    localparam int S0 [4] = '{1, 3, 6, 8};
    localparam int S1 [4] = '{2, 4, 5, 7};

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [NREQ-1:0]     rd_valid;
    logic [NREQ*AW-1:0]  rd_addr;
    logic [NREQ-1:0]     rd_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ*DW-1:0]  rsp_data;
    logic                wr_valid;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [DW-1:0]       wr_mask;
    logic                wr_ready;
    logic [8:0]          mem_CE;
    logic [9*AW-1:0]     mem_A;
    logic [DW-1:0]       mem_D;
    logic [DW-1:0]       mem_WEM;
    logic                mem_WE;
    logic [8*DW-1:0]     mem_Q;

    w6_data2304_rd_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_ready(wr_ready),
        .mem_CE(mem_CE), .mem_A(mem_A), .mem_D(mem_D), .mem_WEM(mem_WEM),
        .mem_WE(mem_WE), .mem_Q(mem_Q)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: one write port, eight registered read ports.
    logic [DW-1:0] mem_arr  [8];
    logic [DW-1:0] init_mem [8];
    logic          load_mem = 1'b1;
    always @(posedge CLK) begin
        if (load_mem) begin
            for (int a = 0; a < 8; a++) mem_arr[a] <= init_mem[a];
        end else if (mem_CE[0] && mem_WE) begin
            mem_arr[mem_A[AW-1:0]] <= (mem_arr[mem_A[AW-1:0]] & ~mem_WEM) | (mem_D & mem_WEM);
        end
        for (int i = 1; i <= 8; i++)
            if (mem_CE[i]) mem_Q[(i-1)*DW +: DW] <= mem_arr[mem_A[i*AW +: AW]];
    end

    // Reference state
    logic [DW-1:0] ref_mem [8];
    int            ptr = 0;

    typedef struct {
        int            req;
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual[63:0] %h required[63:0] %h (cycle %0d)",
                     name, act[63:0], req[63:0], cyc);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Monitor: pops every response due this cycle and compares.
    always @(negedge CLK) begin : monitor
        logic [NREQ-1:0] m;
        exp_t            e;
        m = '0;
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            m[e.req] = 1'b1;
            chkw($sformatf("rsp_data_req%0d", e.req), rsp_data[e.req*DW +: DW], e.data);
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(m));
    end

    // One scheduling cycle: drive, predict with per-bank slot counts, compare grants.
    task automatic do_cycle(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                            input logic wv, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        int              used [4];
        logic [NREQ-1:0] exp_rdy;
        logic [8:0]      exp_ce;
        int              last;
        int              r;
        int              h;
        logic [AW-1:0]   ra;
        exp_t            e;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        rd_valid = v; rd_addr = a;
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
        for (int i = 0; i < 4; i++) used[i] = 0;
        exp_rdy = '0;
        exp_ce  = '0;
        last    = -1;
        if (wv) begin
            used[int'(wa[1:0])] = 1;
            exp_ce[0] = 1'b1;
        end
        for (int k = 0; k < NREQ; k++) begin
            r  = (ptr + k) % NREQ;
            ra = a[r*AW +: AW];
            h  = int'(ra[1:0]);
            if (v[r] && !(wv && ra == wa) && used[h] < 2) begin
                exp_ce[(used[h] == 0) ? S0[h] : S1[h]] = 1'b1;
                used[h]++;
                exp_rdy[r] = 1'b1;
                last = r;
                e.req = r; e.due = cyc + 1; e.data = ref_mem[ra];
                exp_q.push_back(e);
            end
        end
        if (last >= 0) ptr = (last + 1) % NREQ;
        if (wv) ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
        @(negedge CLK);
        chk("rd_ready", 64'(rd_ready), 64'(exp_rdy));
        chk("wr_ready", 64'(wr_ready), 64'(wv));
        chk("mem_CE", 64'(mem_CE), 64'(exp_ce));
    endtask

    task automatic reset_cycle();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        rd_valid = '1;
        rd_addr  = NREQ*AW'($urandom);
        wr_valid = 1'b1;
        wr_addr  = AW'($urandom);
        exp_q.delete();
        ptr = 0;
        @(negedge CLK);
        chk("rst_rd_ready", 64'(rd_ready), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_mem_CE", 64'(mem_CE), 64'(0));
    endtask

    initial begin
        logic [NREQ*AW-1:0] a;
        logic [DW-1:0]      wd;
        logic [DW-1:0]      wm;
        logic [DW-1:0]      old5;
        rd_valid = '0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        for (int i = 0; i < 8; i++) begin
            init_mem[i] = rand_word();
            ref_mem[i]  = init_mem[i];
        end
        reset_cycle();
        reset_cycle();
        load_mem = 1'b0;

        // Spread reads: one per address, all eight ports busy.
        for (int r = 0; r < NREQ; r++) a[r*AW +: AW] = AW'(r);
        do_cycle(8'hFF, a, 1'b0, '0, '0, '0);
        chk("spread_ready", 64'(rd_ready), 64'h0FF);
        chk("spread_ce", 64'(mem_CE), 64'h1FE);

        // Three requesters on one h-bank, two cycles running.
        a = '0;
        for (int r = 0; r < 3; r++) a[r*AW +: AW] = 3'd1;
        do_cycle(8'b0000_0111, a, 1'b0, '0, '0, '0);
        chk("contend1_ready", 64'(rd_ready), 64'h3);
        chk("contend1_ce", 64'(mem_CE), 64'h018);
        do_cycle(8'b0000_0111, a, 1'b0, '0, '0, '0);
        chk("contend2_ready", 64'(rd_ready), 64'h5);

        // Write plus reads to the same h-bank, then read-after-write.
        a = '0;
        a[0*AW +: AW] = 3'd2;
        a[1*AW +: AW] = 3'd6;
        wd = rand_word();
        do_cycle(8'b0000_0011, a, 1'b1, 3'd2, wd, '1);
        chk("wrrd_ready", 64'(rd_ready), 64'h2);
        chk("wrrd_ce", 64'(mem_CE), 64'h021);
        do_cycle(8'b0000_0001, a, 1'b0, '0, '0, '0);
        chk("raw_ready", 64'(rd_ready), 64'h1);
        do_cycle('0, '0, 1'b0, '0, '0, '0);
        chkw("raw_data", rsp_data[0 +: DW], wd);

        // Masked write of all ones over alternate bits.
        old5 = ref_mem[5];
        for (int i = 0; i < DW; i++) wm[i] = (i % 2 == 0);
        do_cycle('0, '0, 1'b1, 3'd5, '1, wm);
        a = '0;
        a[3*AW +: AW] = 3'd5;
        do_cycle(8'b0000_1000, a, 1'b0, '0, '0, '0);
        do_cycle('0, '0, 1'b0, '0, '0, '0);
        chkw("masked_data", rsp_data[3*DW +: DW], old5 | wm);

        // Reset while responses are in flight.
        for (int r = 0; r < NREQ; r++) a[r*AW +: AW] = AW'(r);
        do_cycle(8'hFF, a, 1'b0, '0, '0, '0);
        reset_cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            do_cycle(NREQ'($urandom), NREQ*AW'($urandom), ($urandom_range(0, 2) == 0),
                     AW'($urandom), rand_word(), rand_word());
        end
        do_cycle('0, '0, 1'b0, '0, '0, '0);
        do_cycle('0, '0, 1'b0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
